// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller slice: default sizing and
// the request/service FSM state encoding.
package interrupt_controller_pkg;

  localparam int NUM_IRQ_DEF = 8;
  localparam int VEC_W_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU/flag-block side bundle of the interrupt controller; the controller
// uses the slave view, the environment driving it uses the master view.
interface interrupt_controller_if
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = VEC_W_DEF
);

  logic [NUM_IRQ-1:0] irq_flag;
  logic               cfg_we;
  logic [NUM_IRQ-1:0] cfg_mask;
  logic               gie;
  logic               irq_ack;
  logic               irq_ret;
  logic               irq_req;
  logic [VEC_W-1:0]   irq_vector;
  logic [NUM_IRQ-1:0] irq_clear;
  logic               irq_active;
  logic [NUM_IRQ-1:0] enable_mask;

  modport master (
    output irq_flag, cfg_we, cfg_mask, gie, irq_ack, irq_ret,
    input  irq_req, irq_vector, irq_clear, irq_active, enable_mask
  );

  modport slave (
    input  irq_flag, cfg_we, cfg_mask, gie, irq_ack, irq_ret,
    output irq_req, irq_vector, irq_clear, irq_active, enable_mask
  );

endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [VEC_W-1:0]   idx_o
);

  // Scan from the top so the lowest set bit is the last one to overwrite idx_o.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? VEC_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches the winning source, requests
// the CPU, pulses the source's flag clear on acknowledge, tracks service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = VEC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_controller_if.slave intc_bus
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] clear_q, clear_d;
  logic               req_q, req_d;
  logic               active_q, active_d;

  logic [NUM_IRQ-1:0] eligible_s;
  logic               win_valid_s;
  logic [VEC_W-1:0]   win_idx_s;
  logic               vec_elig_s;

  assign eligible_s = intc_bus.irq_flag & mask_q;
  assign vec_elig_s = eligible_s[vector_q];

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .req_i   (eligible_s),
    .valid_o (win_valid_s),
    .idx_o   (win_idx_s)
  );

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vector_q <= '0;
      mask_q   <= '0;
      clear_q  <= '0;
      req_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      mask_q   <= mask_d;
      clear_q  <= clear_d;
      req_q    <= req_d;
      active_q <= active_d;
    end
  end

  // Next state; in REQ an acknowledge takes precedence over an abort.
  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    mask_d   = intc_bus.cfg_we ? intc_bus.cfg_mask : mask_q;
    case (state_q)
      ST_IDLE: begin
        if (intc_bus.gie && win_valid_s) begin
          state_d  = ST_REQ;
          vector_d = win_idx_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (intc_bus.irq_ack) begin
          state_d = ST_SERVICE;
        end else if (!intc_bus.gie || !vec_elig_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (intc_bus.irq_ret) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values, captured by the register above.
  always_comb begin
    req_d    = (state_d == ST_REQ);
    active_d = (state_d == ST_SERVICE);
    if ((state_q == ST_REQ) && intc_bus.irq_ack) begin
      clear_d = {{(NUM_IRQ-1){1'b0}}, 1'b1} << vector_q;
    end else begin
      clear_d = '0;
    end
  end

  assign intc_bus.irq_req     = req_q;
  assign intc_bus.irq_vector  = vector_q;
  assign intc_bus.irq_clear   = clear_q;
  assign intc_bus.irq_active  = active_q;
  assign intc_bus.enable_mask = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a cycle table of stimulus and
// expected outputs fed through a scoreboard queue, plus reset/latency sequences.
module tb_interrupt_controller;

  typedef struct {
    string      name;
    logic [7:0] flag;
    logic       we;
    logic [7:0] mask;
    logic       gie;
    logic       ack;
    logic       ret;
    logic       e_req;
    logic [2:0] e_vec;
    logic [7:0] e_clr;
    logic       e_act;
    logic [7:0] e_mask;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t rows[$];
  vec_t exp_q[$];

  interrupt_controller_if #(.NUM_IRQ(8), .VEC_W(3)) bus ();

  interrupt_controller #(.NUM_IRQ(8), .VEC_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .intc_bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic [7:0] flag, input logic we,
                     input logic [7:0] mask, input logic gie, input logic ack,
                     input logic ret, input logic e_req, input logic [2:0] e_vec,
                     input logic [7:0] e_clr, input logic e_act, input logic [7:0] e_mask);
    vec_t r;
    r.name = n; r.flag = flag; r.we = we; r.mask = mask; r.gie = gie;
    r.ack = ack; r.ret = ret; r.e_req = e_req; r.e_vec = e_vec;
    r.e_clr = e_clr; r.e_act = e_act; r.e_mask = e_mask;
    rows.push_back(r);
  endtask

  task automatic check_out(input string n, input logic e_req, input logic [2:0] e_vec,
                           input logic [7:0] e_clr, input logic e_act, input logic [7:0] e_mask);
    n_tests++;
    if (bus.irq_req !== e_req || bus.irq_vector !== e_vec || bus.irq_clear !== e_clr ||
        bus.irq_active !== e_act || bus.enable_mask !== e_mask) begin
      n_fail++;
      $display("FAIL %s: got req=%b vec=%0d clr=%h act=%b mask=%h, expected req=%b vec=%0d clr=%h act=%b mask=%h",
               n, bus.irq_req, bus.irq_vector, bus.irq_clear, bus.irq_active, bus.enable_mask,
               e_req, e_vec, e_clr, e_act, e_mask);
    end
  endtask

  task automatic drive(input logic [7:0] flag, input logic we, input logic [7:0] mask,
                       input logic gie, input logic ack, input logic ret);
    bus.irq_flag = flag; bus.cfg_we = we; bus.cfg_mask = mask;
    bus.gie = gie; bus.irq_ack = ack; bus.irq_ret = ret;
  endtask

  initial begin
    vec_t e;
    logic found;

    //   name           flag   we    mask   gie   ack   ret   req  vec   clr    act   mask
    add("no_mask",     8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    add("mask_wr",     8'h28, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    add("req_v3",      8'h28, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'hFF);
    add("ack_v3",      8'h28, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h08, 1'b1, 8'hFF);
    add("svc_ack_ign", 8'h20, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b1, 8'hFF);
    add("ret_v3",      8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 8'hFF);
    add("req_v5",      8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'hFF);
    add("hold_v5",     8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'hFF);
    add("ack_v5",      8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h20, 1'b1, 8'hFF);
    add("ret_v5",      8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 8'hFF);
    add("req_v1",      8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("gie_abort",   8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("gie_off_idle",8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("req_v1_again",8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("ack_gie_drop",8'h02, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h02, 1'b1, 8'hFF);
    add("ret_v1",      8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("idle_ret_ign",8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("mask_01",     8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h01);
    add("masked_a",    8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h01);
    add("masked_b",    8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h01);
    add("mask_02",     8'h02, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h02);
    add("unmask_req",  8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h02);
    add("mask_00_wr",  8'h02, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h00);
    add("mask_abort",  8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h00);
    add("mask_ff",     8'h02, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("req_v1_c",    8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("flag_abort",  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'hFF);
    add("req_v7",      8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'hFF);
    add("ack_v7",      8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 8'h80, 1'b1, 8'hFF);
    add("svc_v7",      8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h00, 1'b1, 8'hFF);

    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_out("reset_state", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: inputs applied at the falling edge, outputs checked after the rising edge.
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i].flag, rows[i].we, rows[i].mask, rows[i].gie, rows[i].ack, rows[i].ret);
      exp_q.push_back(rows[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_out(e.name, e.e_req, e.e_vec, e.e_clr, e.e_act, e.e_mask);
    end

    // Reset while in service: immediate clear of everything, no clear pulse even with ack.
    @(negedge clk);
    reset = 1'b1;
    drive(8'h81, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1 check_out("rst_in_svc", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1 check_out("rst_held", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1 check_out("post_rst_nomask", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    end

    // Bounded wait for a request after enabling source 4.
    @(negedge clk);
    drive(8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.irq_req === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_req_v4: got no request within 4 cycles, expected irq_req=1");
    end
    check_out("req_v4", 1'b1, 3'd4, 8'h00, 1'b0, 8'h10);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    @(posedge clk);
    #1 check_out("ack_v4", 1'b0, 3'd4, 8'h10, 1'b1, 8'h10);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    @(posedge clk);
    #1 check_out("clear_one_cycle", 1'b0, 3'd4, 8'h00, 1'b1, 8'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt sources (2..32).
REQ-002 Parameter VEC_W, default 3, vector width = clog2(NUM_IRQ).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port irq_flag  input  NUM_IRQ  pending flags from the per-source edge-detect flag blocks.
REQ-006 Port cfg_we  input  1  one-cycle write strobe for enable mask.
REQ-007 Port cfg_mask  input  NUM_IRQ  new enable mask, captured when cfg_we=1.
REQ-008 Port gie  input  1  global interrupt enable from CPU status.
REQ-009 Port irq_ack  input  1  CPU accepts the presented request (one-cycle pulse).
REQ-010 Port irq_ret  input  1  CPU finished the handler (one-cycle pulse).
REQ-011 Port irq_req  output  1  interrupt request to CPU.
REQ-012 Port irq_vector  output  VEC_W  index of the source being requested/serviced.
REQ-013 Port irq_clear  output  NUM_IRQ  one-hot one-cycle pulse driving each flag block's clear input.
REQ-014 Port irq_active  output  1  high while a handler is in service.
REQ-015 Port enable_mask  output  NUM_IRQ  current enable mask register readback.

Function
REQ-016 Eligible vector = irq_flag & enable_mask; fixed priority, lowest index highest.
REQ-017 FSM states IDLE, REQ, SERVICE; encoding from shared package.
REQ-018 IDLE: if gie=1 and eligible nonzero, latch winner index into irq_vector, go REQ; otherwise stay.
REQ-019 REQ: irq_req=1; irq_vector held constant regardless of newly arriving higher-priority flags.
REQ-020 REQ, irq_ack=1: irq_clear[irq_vector] pulses high for exactly the following cycle, go SERVICE, irq_req=0 next cycle.
REQ-021 REQ, irq_ack=0 and (gie=0 or latched source no longer eligible): abort to IDLE, irq_req=0 next cycle, no clear pulse.
REQ-022 REQ, irq_ack=1 simultaneous with abort condition: ack wins, follow REQ-020.
REQ-023 SERVICE: irq_active=1, irq_vector held; no new request regardless of flags; irq_ret=1 -> IDLE.
REQ-024 Minimum latency: flag eligible at edge N -> irq_req high after edge N+1; after irq_ret, next request earliest one cycle after return to IDLE.
REQ-025 irq_ack outside REQ and irq_ret outside SERVICE are ignored.
REQ-026 cfg_we updates enable_mask at the next edge in any state; mask change affects eligibility from the following cycle (may trigger REQ-021 abort).
REQ-027 irq_clear is zero in all cycles except the single cycle defined in REQ-020.
REQ-028 Flags are sampled on rising edge only; flag blocks update on falling edge, so flags are stable at sampling.

Reset
REQ-029 reset=1 forces immediately: state IDLE, irq_req=0, irq_vector=0, irq_clear=0, irq_active=0, enable_mask=0.
REQ-030 Reset mid-REQ or mid-SERVICE discards the transaction; no clear pulse generated.
REQ-031 After reset release, no request until cfg_we writes a nonzero mask.

Structure
REQ-032 Shared package holds NUM_IRQ default, VEC_W, FSM state constants (IDLE/REQ/SERVICE).
REQ-033 Combinational fixed-priority encoder is sub-module irq_prio_enc (input NUM_IRQ vector, outputs valid and index).
REQ-034 All outputs registered; no combinational path from irq_ack/irq_ret to irq_req.

Verification
REQ-035 Mask=0xFF, gie=1, irq_flag=0x28 -> irq_req next cycle, irq_vector=3; ack -> irq_clear=0x08 one cycle, irq_active=1.
REQ-036 In REQ on vector 5, raise flag 1 -> irq_vector stays 5; after ack/ret, next request vector 1.
REQ-037 In REQ, drop gie with no ack -> irq_req=0 next cycle, irq_clear stays 0, state IDLE.
REQ-038 In REQ, ack and gie drop same cycle -> clear pulse emitted, SERVICE entered.
REQ-039 Mask=0x01, irq_flag=0x02 -> no request; write mask 0x02 -> request vector 1 within 2 cycles.
REQ-040 Assert reset during SERVICE -> all outputs zero immediately, enable_mask=0, no clear pulse.
